// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage F/D/E/M/W pipeline.
// Produces E-stage forwarding selects, load-use and PC-write stalls and
// flushes, and sequences iterative multi-cycle execute operations.
module hazard_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int CW         = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] RA1D,
  input  logic [3:0] RA2D,
  input  logic [3:0] RA1E,
  input  logic [3:0] RA2E,
  input  logic [3:0] WA3E,
  input  logic [3:0] WA3M,
  input  logic [3:0] WA3W,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemtoRegE,
  input  logic       PCSrcD,
  input  logic       PCSrcE,
  input  logic       PCSrcM,
  input  logic       PCSrcW,
  input  logic       BranchTakenE,
  input  logic       MulStartE,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       FlushD,
  output logic       FlushE,
  output logic       BubbleM,
  output logic       MulBusy,
  output logic       MulDone
);

  typedef enum logic {IDLE, BUSY} state_t;

  // Counter load value: the first cycle in E is spent in IDLE, so BUSY
  // lasts MUL_CYCLES-1 cycles and the final one releases the stall.
  localparam logic [CW-1:0] CNT_LOAD = CW'(MUL_CYCLES - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          mul_done_q;
  logic          mul_stall;
  logic          ldr_stall;
  logic          pc_wr_pend;

  // Forwarding selects: M stage has priority over W, R15 is never forwarded.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (RegWriteM && (RA1E == WA3M) && (RA1E != 4'hF))
      ForwardAE = 2'b10;
    else if (RegWriteW && (RA1E == WA3W) && (RA1E != 4'hF))
      ForwardAE = 2'b01;
    if (RegWriteM && (RA2E == WA3M) && (RA2E != 4'hF))
      ForwardBE = 2'b10;
    else if (RegWriteW && (RA2E == WA3W) && (RA2E != 4'hF))
      ForwardBE = 2'b01;
  end

  // Load-use and pending PC-write detection.
  always_comb begin
    ldr_stall  = MemtoRegE && ((RA1D == WA3E) || (RA2D == WA3E));
    pc_wr_pend = PCSrcD || PCSrcE || PCSrcM;
  end

  // Multi-cycle stall: asserted on the entry cycle and while more than one
  // BUSY cycle remains; reset forces it low so a held MulStartE is ignored.
  always_comb begin
    mul_stall = 1'b0;
    if (!reset) begin
      case (state)
        IDLE:    mul_stall = MulStartE;
        BUSY:    mul_stall = (cnt > CW'(1));
        default: mul_stall = 1'b0;
      endcase
    end
  end

  // Multi-cycle sequencer; the done flag is registered one cycle ahead so it
  // lines up with the final cycle of the operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      mul_done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          mul_done_q <= 1'b0;
          if (MulStartE) begin
            state      <= BUSY;
            cnt        <= CNT_LOAD;
            mul_done_q <= (CNT_LOAD == CW'(1));
          end
        end
        BUSY: begin
          if (cnt > CW'(1)) begin
            cnt        <= cnt - CW'(1);
            mul_done_q <= (cnt == CW'(2));
          end else begin
            state      <= IDLE;
            cnt        <= '0;
            mul_done_q <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          cnt        <= '0;
          mul_done_q <= 1'b0;
        end
      endcase
    end
  end

  // Stall and flush outputs; a flush masked by the multi-cycle stall is
  // recomputed every cycle and lands once the stall drops.
  always_comb begin
    StallF  = ldr_stall || pc_wr_pend || mul_stall;
    StallD  = ldr_stall || mul_stall;
    StallE  = mul_stall;
    BubbleM = mul_stall;
    FlushD  = (pc_wr_pend || PCSrcW || BranchTakenE) && !mul_stall;
    FlushE  = (ldr_stall || BranchTakenE) && !mul_stall;
    MulBusy = (state == BUSY);
    MulDone = mul_done_q;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a driver issues directed and random
// cycles and queues expectations from a behavioural model; a monitor pops
// and compares on every falling edge.
module tb_hazard_ctrl;

  localparam int M = 4;

  typedef struct {
    logic       reset;
    logic [3:0] ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w;
    logic       regwm, regww, memtoreg;
    logic       pcd, pce, pcm, pcw, brtaken, mulstart;
  } stim_t;

  typedef struct {
    logic [1:0] fa, fb;
    logic       sf, sd, se, fd, fe, bm, busy, done;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic       RegWriteM, RegWriteW, MemtoRegE;
  logic       PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, MulStartE;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, FlushD, FlushE, BubbleM, MulBusy, MulDone;

  exp_t  sb[$];
  int    total = 0;
  int    bad   = 0;
  stim_t cur;
  int    pos_eff;
  int    pos_state;

  hazard_ctrl #(.MUL_CYCLES(M), .CW(4)) dut (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
    .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
    .BranchTakenE(BranchTakenE), .MulStartE(MulStartE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .BubbleM(BubbleM),
    .MulBusy(MulBusy), .MulDone(MulDone)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  function automatic stim_t idle();
    stim_t s;
    s = '{reset: 1'b0, ra1d: 4'd0, ra2d: 4'd0, ra1e: 4'd0, ra2e: 4'd0,
          wa3e: 4'd0, wa3m: 4'd0, wa3w: 4'd0, regwm: 1'b0, regww: 1'b0,
          memtoreg: 1'b0, pcd: 1'b0, pce: 1'b0, pcm: 1'b0, pcw: 1'b0,
          brtaken: 1'b0, mulstart: 1'b0};
    return s;
  endfunction

  function automatic logic [1:0] fwdModel(input logic [3:0] ra, input stim_t s);
    if (ra == 4'd15) return 2'd0;
    if (s.regwm && ra == s.wa3m) return 2'd2;
    if (s.regww && ra == s.wa3w) return 2'd1;
    return 2'd0;
  endfunction

  task automatic driveInputs(input stim_t s);
    reset = s.reset; RA1D = s.ra1d; RA2D = s.ra2d; RA1E = s.ra1e; RA2E = s.ra2e;
    WA3E = s.wa3e; WA3M = s.wa3m; WA3W = s.wa3w;
    RegWriteM = s.regwm; RegWriteW = s.regww; MemtoRegE = s.memtoreg;
    PCSrcD = s.pcd; PCSrcE = s.pce; PCSrcM = s.pcm; PCSrcW = s.pcw;
    BranchTakenE = s.brtaken; MulStartE = s.mulstart;
  endtask

  // One cycle: advance the op-position model past the previous cycle, apply
  // the new inputs and queue the expected outputs for this cycle.
  task automatic applyStimulus(input stim_t s);
    exp_t e;
    logic mstall, ldr, pcp;
    @(posedge clk);
    #1;
    if (cur.reset)                    pos_state = 0;
    else if (pos_eff >= 1 && pos_eff < M) pos_state = pos_eff + 1;
    else                              pos_state = 0;
    cur = s;
    driveInputs(s);
    pos_eff = (pos_state == 0 && s.mulstart && !s.reset) ? 1 : pos_state;
    mstall = !s.reset && pos_eff >= 1 && pos_eff < M;
    ldr    = s.memtoreg && (s.ra1d == s.wa3e || s.ra2d == s.wa3e);
    pcp    = s.pcd || s.pce || s.pcm;
    e.fa   = fwdModel(s.ra1e, s);
    e.fb   = fwdModel(s.ra2e, s);
    e.sf   = ldr || pcp || mstall;
    e.sd   = ldr || mstall;
    e.se   = mstall;
    e.bm   = mstall;
    e.fd   = (pcp || s.pcw || s.brtaken) && !mstall;
    e.fe   = (ldr || s.brtaken) && !mstall;
    e.busy = (pos_state >= 2);
    e.done = (pos_state == M);
    sb.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [1:0] act, input logic [1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
    end
  endtask

  // Monitor: every falling edge, compare DUT outputs with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput("ForwardAE", ForwardAE, e.fa);
        checkOutput("ForwardBE", ForwardBE, e.fb);
        checkOutput("StallF", {1'b0, StallF}, {1'b0, e.sf});
        checkOutput("StallD", {1'b0, StallD}, {1'b0, e.sd});
        checkOutput("StallE", {1'b0, StallE}, {1'b0, e.se});
        checkOutput("FlushD", {1'b0, FlushD}, {1'b0, e.fd});
        checkOutput("FlushE", {1'b0, FlushE}, {1'b0, e.fe});
        checkOutput("BubbleM", {1'b0, BubbleM}, {1'b0, e.bm});
        checkOutput("MulBusy", {1'b0, MulBusy}, {1'b0, e.busy});
        checkOutput("MulDone", {1'b0, MulDone}, {1'b0, e.done});
      end
    end
  end

  // Stimulus: reset, directed scenarios, then random traffic.
  initial begin
    stim_t s;
    int    wait_cnt;
    cur = idle();
    cur.reset = 1'b1;
    pos_eff = 0;
    pos_state = 0;
    driveInputs(cur);

    s = idle(); s.reset = 1'b1; s.mulstart = 1'b1;
    applyStimulus(s);
    applyStimulus(s);

    // Forwarding priority M over W, then W only, then R15.
    s = idle(); s.regwm = 1; s.regww = 1; s.wa3m = 3; s.wa3w = 3; s.ra1e = 3; s.ra2e = 3;
    applyStimulus(s);
    s.regwm = 0;
    applyStimulus(s);
    s.ra1e = 15; s.wa3m = 15; s.wa3w = 15; s.regwm = 1;
    applyStimulus(s);

    // Load-use, then cleared.
    s = idle(); s.memtoreg = 1; s.wa3e = 5; s.ra2d = 5; s.ra1d = 2;
    applyStimulus(s);
    s.memtoreg = 0;
    applyStimulus(s);

    // Branch taken, then PC write in D alone.
    s = idle(); s.brtaken = 1;
    applyStimulus(s);
    s = idle(); s.pcd = 1;
    applyStimulus(s);

    // Two back-to-back multiplies with MulStartE held.
    s = idle(); s.mulstart = 1;
    repeat (2 * M + 1) applyStimulus(s);
    s = idle();
    applyStimulus(s);

    // Branch arrives while BUSY with cnt=2: masked until the final cycle.
    s = idle(); s.mulstart = 1;
    repeat (2) applyStimulus(s);
    s.brtaken = 1; s.mulstart = 0;
    repeat (3) applyStimulus(s);

    // Reset in the second BUSY cycle, with MulStartE still high.
    s = idle(); s.mulstart = 1;
    repeat (2) applyStimulus(s);
    s.reset = 1;
    repeat (2) applyStimulus(s);
    s.reset = 0; s.mulstart = 0;
    repeat (2) applyStimulus(s);

    // Random traffic over a small address set to provoke hazards.
    for (int i = 0; i < 600; i++) begin
      s = idle();
      s.reset    = ($urandom_range(0, 59) == 0);
      s.ra1d     = ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 3));
      s.ra2d     = 4'($urandom_range(0, 3));
      s.ra1e     = ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 3));
      s.ra2e     = ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 3));
      s.wa3e     = 4'($urandom_range(0, 3));
      s.wa3m     = ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 3));
      s.wa3w     = ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 3));
      s.regwm    = 1'($urandom_range(0, 1));
      s.regww    = 1'($urandom_range(0, 1));
      s.memtoreg = ($urandom_range(0, 3) == 0);
      s.pcd      = ($urandom_range(0, 7) == 0);
      s.pce      = ($urandom_range(0, 7) == 0);
      s.pcm      = ($urandom_range(0, 7) == 0);
      s.pcw      = ($urandom_range(0, 7) == 0);
      s.brtaken  = ($urandom_range(0, 7) == 0);
      s.mulstart = ($urandom_range(0, 2) == 0);
      applyStimulus(s);
    end

    wait_cnt = 0;
    while (sb.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and sequencing controller for the 5-stage ARM core (F/D/E/M/W).
- Generates the E-stage operand forwarding selects.
- Detects load-use hazards and PC-write/branch hazards, driving stall and flush controls for the pipeline registers.
- Sequences multi-cycle execute operations (iterative MUL) with an FSM and counter, holding E until the result is ready.

Parameters:
- MUL_CYCLES, 4, total cycles a multi-cycle op occupies E; legal range 2..15.
- CW, 4, counter width; must satisfy 2^CW > MUL_CYCLES.

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- RA1D, RA2D  input  4  source register addresses in D
- RA1E, RA2E  input  4  source register addresses in E
- WA3E, WA3M, WA3W  input  4  destination addresses in E/M/W
- RegWriteM, RegWriteW  input  1  register write enables in M/W
- MemtoRegE  input  1  E holds a load
- PCSrcD, PCSrcE, PCSrcM, PCSrcW  input  1  instruction in stage writes PC
- BranchTakenE  input  1  branch in E resolved taken
- MulStartE  input  1  E holds a multi-cycle op; held high while E is stalled
- ForwardAE, ForwardBE  output  2  00 register file, 01 result W, 10 ALU result M
- StallF, StallD, StallE  output  1  hold the pipeline register
- FlushD, FlushE  output  1  clear the pipeline register to a bubble
- BubbleM  output  1  load a bubble into the E/M register
- MulBusy  output  1  FSM in BUSY
- MulDone  output  1  one-cycle pulse in the final cycle of a multi-cycle op

Behaviour:
- Forwarding (combinational), shown for A; B is identical with RA2E:
  - 10 if RegWriteM and RA1E==WA3M and RA1E!=4'hF.
  - Else 01 if RegWriteW and RA1E==WA3W and RA1E!=4'hF.
  - Else 00.
  - M has priority over W.
- LDRStall = MemtoRegE & ((RA1D==WA3E) | (RA2D==WA3E)).
- PCWrPend = PCSrcD | PCSrcE | PCSrcM.
- Multi-cycle FSM has states IDLE and BUSY, plus a CW-bit counter cnt.
  - IDLE with MulStartE=1: MulStall=1, cnt<=MUL_CYCLES-1, go to BUSY.
  - BUSY with cnt>1: MulStall=1, cnt<=cnt-1.
  - BUSY with cnt==1: MulStall=0, MulDone=1, cnt<=0, go to IDLE.
  - Net effect: the op occupies E for exactly MUL_CYCLES cycles with MulStall high for MUL_CYCLES-1 of them.
  - MulStartE is ignored in BUSY (no retrigger). A new op entering E the cycle after completion starts a fresh sequence.
  - MulDone=0 in all other cycles. MulBusy = (state==BUSY), registered.
- Output equations:
  - StallF = LDRStall | PCWrPend | MulStall.
  - StallD = LDRStall | MulStall.
  - StallE = MulStall.
  - BubbleM = MulStall.
  - FlushD = (PCWrPend | PCSrcW | BranchTakenE) & ~MulStall.
  - FlushE = (LDRStall | BranchTakenE) & ~MulStall.
- Flush overrides stall at the pipeline register. A flush that is masked by MulStall re-evaluates every cycle and takes effect once the stall releases.
- Reset (synchronous):
  - state<=IDLE, cnt<=0, MulBusy=0, MulDone=0.
  - While reset is high, MulStartE is ignored and MulStall=0.
  - Reset mid-op aborts the sequence; the cycle after reset deasserts is IDLE.
  - Combinational forwarding, load-use and flush outputs keep following their inputs during reset.
- Simultaneous LDRStall and MulStall: stall outputs are the OR; FlushE=0 (E is held, not bubbled).

Test Plan:
- Forwarding priority: RegWriteM=RegWriteW=1, WA3M=WA3W=RA1E=3 -> ForwardAE=10. Drop RegWriteM -> 01. RA1E=15 -> 00.
- Load-use: MemtoRegE=1, WA3E=5, RA2D=5 -> StallF=StallD=FlushE=1, StallE=0. MemtoRegE=0 -> all 0.
- Branch: BranchTakenE=1 -> FlushD=FlushE=1. PCSrcD=1 alone -> StallF=1, FlushD=1, FlushE=0.
- Multiply, MUL_CYCLES=4: MulStartE held high -> StallE=StallD=StallF=BubbleM=1 for exactly 3 cycles, MulBusy=1 for cycles 2-4, MulDone=1 in cycle 4 only. With MulStartE=1 again in cycle 5, a new 3-cycle stall follows.
- Masked flush: BranchTakenE=1 while in BUSY with cnt=2 -> FlushD=FlushE=0 until cnt==1, then FlushE=1.
- Reset mid-op: reset asserted in the 2nd BUSY cycle -> next cycle MulBusy=0, MulStall=0, cnt=0. MulStartE high during reset causes no transition.
